// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse transmitter
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    LETTER_GAP,
    WORD_GAP
  } morseState_t;

  // Phase lengths in Morse time units
  localparam logic [2:0] DOT_U        = 3'd1;
  localparam logic [2:0] DASH_U       = 3'd3;
  localparam logic [2:0] SYM_GAP_U    = 3'd1;
  localparam logic [2:0] LETTER_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U   = 3'd7;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UZ    = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;

  // Lowercase letters fold onto uppercase; everything else passes through
  function automatic logic [7:0] toUpper(input logic [7:0] c);
    if (c >= ASCII_LA && c <= ASCII_LZ) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - ASCII to Morse element pattern lookup
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [2:0] len,
  output logic [3:0] pattern,
  output logic       is_space,
  output logic       is_valid
);

  logic [7:0] upper;

  assign upper    = toUpper(ascii);
  assign is_space = (ascii == ASCII_SPACE);
  assign is_valid = (upper >= ASCII_UA) && (upper <= ASCII_UZ);

  // Element i is pattern[len-1-i]; 1 = dash, first element is the MSB of the field
  always_comb begin
    len     = 3'd0;
    pattern = 4'b0000;
    case (upper)
      8'h41: {len, pattern} = {3'd2, 4'b0001}; // A .-
      8'h42: {len, pattern} = {3'd4, 4'b1000}; // B -...
      8'h43: {len, pattern} = {3'd4, 4'b1010}; // C -.-.
      8'h44: {len, pattern} = {3'd3, 4'b0100}; // D -..
      8'h45: {len, pattern} = {3'd1, 4'b0000}; // E .
      8'h46: {len, pattern} = {3'd4, 4'b0010}; // F ..-.
      8'h47: {len, pattern} = {3'd3, 4'b0110}; // G --.
      8'h48: {len, pattern} = {3'd4, 4'b0000}; // H ....
      8'h49: {len, pattern} = {3'd2, 4'b0000}; // I ..
      8'h4A: {len, pattern} = {3'd4, 4'b0111}; // J .---
      8'h4B: {len, pattern} = {3'd3, 4'b0101}; // K -.-
      8'h4C: {len, pattern} = {3'd4, 4'b0100}; // L .-..
      8'h4D: {len, pattern} = {3'd2, 4'b0011}; // M --
      8'h4E: {len, pattern} = {3'd2, 4'b0010}; // N -.
      8'h4F: {len, pattern} = {3'd3, 4'b0111}; // O ---
      8'h50: {len, pattern} = {3'd4, 4'b0110}; // P .--.
      8'h51: {len, pattern} = {3'd4, 4'b1101}; // Q --.-
      8'h52: {len, pattern} = {3'd3, 4'b0010}; // R .-.
      8'h53: {len, pattern} = {3'd3, 4'b0000}; // S ...
      8'h54: {len, pattern} = {3'd1, 4'b0001}; // T -
      8'h55: {len, pattern} = {3'd3, 4'b0001}; // U ..-
      8'h56: {len, pattern} = {3'd4, 4'b0001}; // V ...-
      8'h57: {len, pattern} = {3'd3, 4'b0011}; // W .--
      8'h58: {len, pattern} = {3'd4, 4'b1001}; // X -..-
      8'h59: {len, pattern} = {3'd4, 4'b1011}; // Y -.--
      8'h5A: {len, pattern} = {3'd4, 4'b1100}; // Z --..
      default: {len, pattern} = {3'd0, 4'b0000};
    endcase
  end

endmodule

// File: rtl/morse_encoder_tx.sv
// rtl/morse_encoder_tx.sv - ASCII to timed Morse key transmitter
module morse_encoder_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letter_in,
  input  logic       letter_valid,
  output logic       letter_ready,
  output logic       key_out,
  output logic       busy,
  output logic       bad_letter
);

  morseState_t      state, stateNext;
  logic [CNT_W-1:0] cycleCnt;
  logic [2:0]       unitCnt;
  logic [2:0]       elemIdx;
  logic [2:0]       lenReg;
  logic [3:0]       patReg;
  logic [2:0]       lutLen;
  logic [3:0]       lutPat;
  logic             lutSpace, lutValid;
  logic             accept;
  logic [1:0]       bitSel;
  logic             curIsDash;
  logic [2:0]       phaseUnits;
  logic             unitEnd, phaseDone, lastElem;

  morse_lut lut (
    .ascii    (letter_in),
    .len      (lutLen),
    .pattern  (lutPat),
    .is_space (lutSpace),
    .is_valid (lutValid)
  );

  assign letter_ready = (state == IDLE);
  assign accept       = letter_valid && letter_ready;

  // Current element: walk the latched pattern from its MSB down
  assign bitSel    = 2'(lenReg - 3'd1 - elemIdx);
  assign curIsDash = patReg[bitSel];
  assign lastElem  = (elemIdx == lenReg - 3'd1);
  assign unitEnd   = (cycleCnt == CNT_W'(UNIT_CYCLES - 1));
  assign phaseDone = unitEnd && (unitCnt == phaseUnits - 3'd1);

  // Length of the phase the FSM is currently in, in units
  always_comb begin
    phaseUnits = DOT_U;
    case (state)
      MARK:       phaseUnits = curIsDash ? DASH_U : DOT_U;
      SYM_GAP:    phaseUnits = SYM_GAP_U;
      LETTER_GAP: phaseUnits = LETTER_GAP_U;
      WORD_GAP:   phaseUnits = WORD_GAP_U;
      default:    phaseUnits = DOT_U;
    endcase
  end

  // Next-state logic; unsupported characters are consumed without leaving IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (lutValid)      stateNext = MARK;
          else if (lutSpace) stateNext = WORD_GAP;
        end
      end
      MARK:       if (phaseDone) stateNext = lastElem ? LETTER_GAP : SYM_GAP;
      SYM_GAP:    if (phaseDone) stateNext = MARK;
      LETTER_GAP: if (phaseDone) stateNext = IDLE;
      WORD_GAP:   if (phaseDone) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Unit timing, element index and latched LUT result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
      unitCnt  <= 3'd0;
      elemIdx  <= 3'd0;
      lenReg   <= 3'd0;
      patReg   <= 4'b0000;
    end else begin
      if (stateNext != state) begin
        cycleCnt <= '0;
        unitCnt  <= 3'd0;
      end else if (state != IDLE) begin
        if (unitEnd) begin
          cycleCnt <= '0;
          unitCnt  <= unitCnt + 3'd1;
        end else begin
          cycleCnt <= cycleCnt + CNT_W'(1);
        end
      end
      if (accept) begin
        lenReg  <= lutLen;
        patReg  <= lutPat;
        elemIdx <= 3'd0;
      end else if (state == SYM_GAP && phaseDone) begin
        elemIdx <= elemIdx + 3'd1;
      end
    end
  end

  // Registered outputs follow the state being entered so key_out rises on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_out    <= 1'b0;
      busy       <= 1'b0;
      bad_letter <= 1'b0;
    end else begin
      key_out    <= (stateNext == MARK);
      busy       <= (stateNext != IDLE);
      bad_letter <= accept && !lutValid && !lutSpace;
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// tb/tb_morse_encoder_tx.sv - scoreboard bench for morse_encoder_tx
module tb_morse_encoder_tx;

  localparam int UC = 4;

  logic       clk;
  logic       reset;
  logic [7:0] letter_in;
  logic       letter_valid;
  logic       letter_ready;
  logic       key_out;
  logic       busy;
  logic       bad_letter;

  int nCmp = 0;
  int nBad = 0;

  typedef struct packed {
    logic key;
    logic busy;
    logic ready;
    logic bad;
    logic first;
  } expItem_t;

  expItem_t expQ[$];

  string morseTab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                           "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                           "..-", "...-", ".--", "-..-", "-.--", "--.."};

  morse_encoder_tx #(.UNIT_CYCLES(UC), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .letter_in    (letter_in),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .key_out      (key_out),
    .busy         (busy),
    .bad_letter   (bad_letter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushRun(input logic k, input logic b, input logic r, input logic bd,
                         input int n, input logic f);
    expItem_t it;
    for (int i = 0; i < n; i++) begin
      it.key = k; it.busy = b; it.ready = r; it.bad = bd; it.first = f && (i == 0);
      expQ.push_back(it);
    end
  endtask

  // Expected per-cycle behaviour for one character, starting the cycle after its accept edge
  task automatic pushChar(input logic [7:0] ch);
    logic [7:0] up;
    string code;
    up = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    if (ch == 8'h20) begin
      pushRun(1'b0, 1'b1, 1'b0, 1'b0, 7 * UC, 1'b1);
      pushRun(1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    end else if (up >= 8'h41 && up <= 8'h5A) begin
      code = morseTab[up - 8'h41];
      for (int i = 0; i < code.len(); i++) begin
        pushRun(1'b1, 1'b1, 1'b0, 1'b0, (code[i] == "-") ? 3 * UC : UC, i == 0);
        if (i < code.len() - 1) pushRun(1'b0, 1'b1, 1'b0, 1'b0, UC, 1'b0);
      end
      pushRun(1'b0, 1'b1, 1'b0, 1'b0, 3 * UC, 1'b0);
      pushRun(1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    end else begin
      pushRun(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    end
  endtask

  task automatic pushMsg(input string msg);
    for (int i = 0; i < msg.len(); i++) pushChar(msg[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1; letter_valid = 1'b0; letter_in = 8'h00;
    repeat (3) @(negedge clk);
    nCmp++;
    if ({key_out, busy, bad_letter, letter_ready} !== 4'b0001) begin
      nBad++;
      $display("FAIL reset_hold key/busy/bad/ready=%b%b%b%b expected 0001", key_out, busy, bad_letter, letter_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    nCmp++;
    if ({key_out, busy, bad_letter, letter_ready} !== 4'b0001) begin
      nBad++;
      $display("FAIL reset_release key/busy/bad/ready=%b%b%b%b expected 0001", key_out, busy, bad_letter, letter_ready);
    end
  endtask

  task automatic test_letters();
    string msgs [5] = '{"E", "A", "qQ", "ABCDEFGHIJKLMNOPQRSTUVWXYZ", "abcxyz"};
    expItem_t e;
    int idx;
    for (int m = 0; m < 5; m++) begin
      pushMsg(msgs[m]);
      idx = 0; letter_in = msgs[m][0]; letter_valid = 1'b1;
      for (int k = 0; k < 20000 && expQ.size() > 0; k++) begin
        @(negedge clk);
        e = expQ.pop_front();
        nCmp++;
        if ({key_out, busy, letter_ready, bad_letter} !== {e.key, e.busy, e.ready, e.bad}) begin
          nBad++;
          $display("FAIL letters msg=%s cyc=%0d key/busy/ready/bad=%b%b%b%b expected %b%b%b%b", msgs[m], k,
                   key_out, busy, letter_ready, bad_letter, e.key, e.busy, e.ready, e.bad);
        end
        if (e.first) begin
          idx++;
          if (idx < msgs[m].len()) letter_in = msgs[m][idx]; else letter_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_space();
    string msgs [2] = '{" ", "E E"};
    expItem_t e;
    int idx;
    for (int m = 0; m < 2; m++) begin
      pushMsg(msgs[m]);
      idx = 0; letter_in = msgs[m][0]; letter_valid = 1'b1;
      for (int k = 0; k < 2000 && expQ.size() > 0; k++) begin
        @(negedge clk);
        e = expQ.pop_front();
        nCmp++;
        if ({key_out, busy, letter_ready, bad_letter} !== {e.key, e.busy, e.ready, e.bad}) begin
          nBad++;
          $display("FAIL space msg='%s' cyc=%0d key/busy/ready/bad=%b%b%b%b expected %b%b%b%b", msgs[m], k,
                   key_out, busy, letter_ready, bad_letter, e.key, e.busy, e.ready, e.bad);
        end
        if (e.first) begin
          idx++;
          if (idx < msgs[m].len()) letter_in = msgs[m][idx]; else letter_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_bad_letter();
    string msg = "5@[`{T";
    expItem_t e;
    int idx;
    pushMsg(msg);
    idx = 0; letter_in = msg[0]; letter_valid = 1'b1;
    for (int k = 0; k < 2000 && expQ.size() > 0; k++) begin
      @(negedge clk);
      e = expQ.pop_front();
      nCmp++;
      if ({key_out, busy, letter_ready, bad_letter} !== {e.key, e.busy, e.ready, e.bad}) begin
        nBad++;
        $display("FAIL bad_letter cyc=%0d key/busy/ready/bad=%b%b%b%b expected %b%b%b%b", k,
                 key_out, busy, letter_ready, bad_letter, e.key, e.busy, e.ready, e.bad);
      end
      if (e.first) begin
        idx++;
        if (idx < msg.len()) letter_in = msg[idx]; else letter_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    string msg = "SOS";
    expItem_t e;
    int idx;
    pushMsg(msg);
    idx = 0; letter_in = msg[0]; letter_valid = 1'b1;
    for (int k = 0; k < 2000 && expQ.size() > 0; k++) begin
      @(negedge clk);
      e = expQ.pop_front();
      nCmp++;
      if ({key_out, busy, letter_ready, bad_letter} !== {e.key, e.busy, e.ready, e.bad}) begin
        nBad++;
        $display("FAIL back_to_back cyc=%0d key/busy/ready/bad=%b%b%b%b expected %b%b%b%b", k,
                 key_out, busy, letter_ready, bad_letter, e.key, e.busy, e.ready, e.bad);
      end
      if (e.first) begin
        idx++;
        if (idx < msg.len()) letter_in = msg[idx]; else letter_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    string msg = "E";
    expItem_t e;
    int idx;
    letter_in = "T"; letter_valid = 1'b1;
    @(negedge clk);
    letter_valid = 1'b0;
    nCmp++;
    if (key_out !== 1'b1) begin
      nBad++;
      $display("FAIL mid_dash_start key_out=%b expected 1", key_out);
    end
    repeat (UC) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nCmp++;
    if ({key_out, busy, letter_ready} !== 3'b001) begin
      nBad++;
      $display("FAIL async_reset key/busy/ready=%b%b%b expected 001", key_out, busy, letter_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    pushMsg(msg);
    idx = 0; letter_in = msg[0]; letter_valid = 1'b1;
    for (int k = 0; k < 2000 && expQ.size() > 0; k++) begin
      @(negedge clk);
      e = expQ.pop_front();
      nCmp++;
      if ({key_out, busy, letter_ready, bad_letter} !== {e.key, e.busy, e.ready, e.bad}) begin
        nBad++;
        $display("FAIL after_reset cyc=%0d key/busy/ready/bad=%b%b%b%b expected %b%b%b%b", k,
                 key_out, busy, letter_ready, bad_letter, e.key, e.busy, e.ready, e.bad);
      end
      if (e.first) begin
        idx++;
        if (idx < msg.len()) letter_in = msg[idx]; else letter_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_letters();
    test_space();
    test_bad_letter();
    test_back_to_back();
    test_reset_mid_symbol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
